// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_add_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/fa_bit.sv
// Combinational 1-bit full adder built from two half-adder stages.
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum_c,
  output logic cout_c
);

  logic ha0_sum;
  logic ha0_carry;
  logic ha1_carry;

  always_comb begin
    ha0_sum   = a ^ b;
    ha0_carry = a & b;
    sum_c     = ha0_sum ^ cin;
    ha1_carry = ha0_sum & cin;
    cout_c    = ha0_carry | ha1_carry;
  end

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder cell plus a carry flop, LSB first,
// one bit per cycle, with an IDLE/RUN/DONE handshake.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic fa_sum;
  logic fa_cout;

  fa_bit u_fa (
    .a      (a_q[0]),
    .b      (b_q[0]),
    .cin    (carry_q),
    .sum_c  (fa_sum),
    .cout_c (fa_cout)
  );

  // Next-state and datapath control
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE, DONE: begin
        state_d = start ? RUN : IDLE;
        if (start) begin
          a_d     = op_a;
          b_d     = op_b;
          res_d   = '0;
          carry_d = 1'b0;
          cnt_d   = '0;
        end
      end
      RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        res_d   = {fa_sum, res_q[WIDTH-1:1]};
        carry_d = fa_cout;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          state_d = DONE;
          sum_d   = {fa_sum, res_q[WIDTH-1:1]};
          cout_d  = fa_cout;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl at WIDTH=8 and WIDTH=4.
module tb_serial_add_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] op_a, op_b;
  logic       busy, done, cout;
  logic [7:0] sum;

  logic       rst4;
  logic       start4;
  logic [3:0] a4, b4;
  logic       busy4, done4, cout4;
  logic [3:0] sum4;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  serial_add_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst4), .start(start4), .op_a(a4), .op_b(b4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One WIDTH=8 operation from IDLE/DONE; optionally scramble inputs and pulse start in RUN.
  task automatic run8(input logic [7:0] a, input logic [7:0] b,
                      input bit scramble, input int pulse_at);
    logic [8:0] expv;
    logic [8:0] prev;
    expv = 9'(a) + 9'(b);
    prev = {cout, sum};
    @(negedge clk);
    start = 1'b1; op_a = a; op_b = b;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      chk("run_busy", 64'(busy), 64'd1);
      chk("run_done", 64'(done), 64'd0);
      chk("run_hold", 64'({cout, sum}), 64'(prev));
      if (scramble) begin
        op_a = 8'($urandom);
        op_b = 8'($urandom);
      end
      start = (i == pulse_at);
      @(negedge clk);
    end
    start = 1'b0;
    chk("done_pulse", 64'(done), 64'd1);
    chk("done_busy", 64'(busy), 64'd0);
    chk("result", 64'({cout, sum}), 64'(expv));
    @(negedge clk);
    chk("done_single", 64'(done), 64'd0);
    chk("idle_hold", 64'({cout, sum}), 64'(expv));
  endtask

  initial begin
    logic [8:0] expv;
    logic [4:0] exp4;
    int n;

    rst = 1'b1; start = 1'b0; op_a = '0; op_b = '0;
    rst4 = 1'b1; start4 = 1'b0; a4 = '0; b4 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0; rst4 = 1'b0;

    // Reset then idle
    for (int i = 0; i < 20; i++) begin
      chk("idle_busy", 64'(busy), 64'd0);
      chk("idle_done", 64'(done), 64'd0);
      chk("idle_res", 64'({cout, sum}), 64'd0);
      @(negedge clk);
    end

    run8(8'hFF, 8'h01, 1'b0, 0);
    run8(8'hA5, 8'h5A, 1'b1, 0);
    run8(8'h12, 8'h34, 1'b0, 3);
    for (int k = 0; k < 6; k++) run8(8'($urandom), 8'($urandom), 1'b1, k);

    // Start held across DONE: second op accepted, second done at cycle 18
    @(negedge clk);
    start = 1'b1; op_a = 8'h12; op_b = 8'h34;
    for (int c = 1; c <= 19; c++) begin
      @(negedge clk);
      if (c == 9) begin
        op_a = 8'h80; op_b = 8'h80;
      end
      if (c == 10) start = 1'b0;
      chk("held_done", 64'(done), 64'((c == 9) || (c == 18)));
      chk("held_busy", 64'(busy), 64'((c <= 17) && (c != 9)));
      if (c == 9)  chk("held_res1", 64'({cout, sum}), 64'h046);
      if (c == 18) chk("held_res2", 64'({cout, sum}), 64'h100);
    end

    // Reset during RUN aborts with no done
    @(negedge clk);
    start = 1'b1; op_a = 8'($urandom); op_b = 8'($urandom);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_res", 64'({cout, sum}), 64'd0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("abort_nodone", 64'(done), 64'd0);
      chk("abort_idle", 64'(busy), 64'd0);
    end

    // Exhaustive WIDTH=4, back-to-back from DONE
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        exp4 = 5'(a) + 5'(b);
        start4 = 1'b1; a4 = 4'(a); b4 = 4'(b);
        @(negedge clk);
        start4 = 1'b0;
        n = 1;
        while (!done4 && n < 10) begin
          @(negedge clk);
          n++;
        end
        chk("x4_latency", 64'(n), 64'd5);
        chk("x4_result", 64'({cout4, sum4}), 64'(exp4));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
